// File: rtl/leb128_decoder_pkg.sv
// Shared definitions for the LEB128 immediate decoder: FSM encodings,
// encoding-length limits, the trap code raised on a malformed immediate,
// and the small pure helpers used by the decode datapath.
package leb128_decoder_pkg;

    // Decoder FSM encoding. The value is also what a debugger sees when
    // probing the state register.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // Longest legal encodings: ceil(32/7) and ceil(64/7) bytes.
    localparam int DEF_MAX_BYTES_32 = 5;
    localparam int DEF_MAX_BYTES_64 = 10;

    // Trap code the cpu raises when the decoder flags a malformed immediate.
    localparam logic [7:0] TRAP_LEB128_MALFORMED = 8'h1C;

    // Checks the payload of the byte that sits at the maximum encoding length.
    // Only the bits that still land inside the target width may carry
    // information; the rest must be zero (unsigned) or copies of the sign
    // (signed).
    function automatic logic last_byte_ok(input logic [6:0] payload,
                                          input logic       sgn,
                                          input logic       w64);
        logic ok;
        if (w64) begin
            if (sgn) ok = (payload == 7'h00) || (payload == 7'h7F);
            else     ok = (payload[6:1] == 6'h00);
        end else begin
            if (sgn) ok = (payload[6:3] == 4'h0) || (payload[6:3] == 4'hF);
            else     ok = (payload[6:4] == 3'h0);
        end
        return ok;
    endfunction

    // Mask with every bit at position >= from_bit set. A position of 64 or
    // more yields an empty mask.
    function automatic logic [63:0] upper_mask(input logic [7:0] from_bit);
        return ~((64'd1 << from_bit) - 64'd1);
    endfunction

endpackage

// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder between the ROM byte stream and the execute
// stage. Accepts one encoded byte per handshake and produces a 64-bit
// immediate (32-bit targets are zero-extended two's-complement values),
// the number of bytes consumed, and an error flag for malformed encodings.
//
// Handshakes (both sides use strict valid/ready): a byte transfers on any
// rising edge where in_valid && in_ready; a result transfers on any rising
// edge where out_valid && out_ready. Neither valid depends combinationally
// on the matching ready; in_ready and out_valid come straight from state.
module leb128_decoder
    import leb128_decoder_pkg::*;
#(
    parameter int MAX_BYTES_32 = DEF_MAX_BYTES_32,
    parameter int MAX_BYTES_64 = DEF_MAX_BYTES_64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic        is_64,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_value,
    output logic [3:0]  out_length,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        error,
    output logic        busy
);

    state_t      state;
    state_t      state_next;

    // Decode context latched at start.
    logic        sgn_q;
    logic        w64_q;

    // Accumulated payload bits, next bit position, bytes consumed so far.
    logic [63:0] acc;
    logic [6:0]  shift;
    logic [3:0]  count;

    // Result registers presented while in DONE.
    logic [63:0] value_q;
    logic [3:0]  length_q;

    // Datapath helpers.
    logic        accept;
    logic        is_last;
    logic [6:0]  payload;
    logic [3:0]  count_inc;
    logic [3:0]  max_count;
    logic        at_limit;
    logic        last_ok;
    logic [63:0] acc_next;
    logic [7:0]  sx_from;
    logic [7:0]  width;
    logic [63:0] final_value;
    logic        good_final;
    logic        bad_byte;

    // Byte acceptance, length-limit and final-byte validity decisions.
    always_comb begin
        accept    = (state == ST_DECODE) && in_valid;
        is_last   = ~in_byte[7];
        payload   = in_byte[6:0];
        count_inc = count + 4'd1;
        max_count = w64_q ? 4'(MAX_BYTES_64) : 4'(MAX_BYTES_32);
        at_limit  = (count_inc == max_count);
        // The range check only applies to the byte at the maximum length;
        // shorter encodings cannot overflow the target width.
        last_ok   = !at_limit || last_byte_ok(payload, sgn_q, w64_q);
        // Final byte that passes its check, vs. a final byte that fails or a
        // continuation byte that would exceed the maximum length.
        good_final = accept && is_last && last_ok;
        bad_byte   = accept && ((is_last && !last_ok) || (!is_last && at_limit));
    end

    // Merge the incoming payload and build the finalized immediate.
    always_comb begin
        acc_next    = acc | ({57'd0, payload} << shift);
        sx_from     = {1'b0, shift} + 8'd7;
        width       = w64_q ? 8'd64 : 8'd32;
        final_value = acc_next;
        // Sign extension from the top payload bit of the final byte.
        if (sgn_q && payload[6] && (sx_from < width)) begin
            final_value = final_value | upper_mask(sx_from);
        end
        // 32-bit targets keep only the low word.
        if (!w64_q) begin
            final_value[63:32] = 32'd0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (good_final)    state_next = ST_DONE;
                else if (bad_byte) state_next = ST_ERROR;
            end
            ST_DONE: begin
                if (out_ready) state_next = ST_IDLE;
            end
            ST_ERROR: begin
                // The start that clears the error is consumed by this exit.
                if (start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded directly from state and the result registers.
    always_comb begin
        in_ready   = (state == ST_DECODE);
        out_valid  = (state == ST_DONE);
        error      = (state == ST_ERROR);
        busy       = (state != ST_IDLE);
        out_value  = value_q;
        out_length = length_q;
    end

    // Decode context, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sgn_q    <= 1'b0;
            w64_q    <= 1'b0;
            acc      <= 64'd0;
            shift    <= 7'd0;
            count    <= 4'd0;
            value_q  <= 64'd0;
            length_q <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sgn_q <= is_signed;
                        w64_q <= is_64;
                        acc   <= 64'd0;
                        shift <= 7'd0;
                        count <= 4'd0;
                    end
                end
                ST_DECODE: begin
                    if (accept) begin
                        acc   <= acc_next;
                        shift <= shift + 7'd7;
                        count <= count_inc;
                    end
                    if (good_final) begin
                        value_q  <= final_value;
                        length_q <= count_inc;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        value_q  <= 64'd0;
                        length_q <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Self-checking bench for leb128_decoder: directed vectors, length-limit
// boundaries, malformed encodings, backpressure, mid-decode reset and
// randomized back-to-back immediates from a reference encoder.
module tb_leb128_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic        is_64;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_value;
    logic [3:0]  out_length;
    logic        out_valid;
    logic        out_ready;
    logic        error;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues: filled when a decode is launched, drained when the
    // decoder reports its result.
    logic [63:0] exp_q[$];
    logic [3:0]  exp_len_q[$];
    logic        exp_err_q[$];

    logic [7:0]  stim[0:15];

    typedef struct {
        bit          sgn;
        bit          w64;
        int          n;
        logic [79:0] bytes;
        logic [63:0] val;
        logic [3:0]  len;
        bit          err;
    } case_t;

    leb128_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .is_64      (is_64),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_value  (out_value),
        .out_length (out_length),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .error      (error),
        .busy       (busy)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------

    task automatic load_bytes(input logic [79:0] b);
        for (int i = 0; i < 10; i++) stim[i] = b[8*i +: 8];
    endtask

    // Starts a decode, feeds stim[0..n-1] with optional idle gaps, and waits
    // for either a result or an error. lat counts negedges between the last
    // byte transfer and the first view of the outcome.
    task automatic decode(input bit sgn, input bit w64, input int n, input bit gaps,
                          output logic [63:0] val, output logic [3:0] len,
                          output logic vld, output logic err,
                          output int lat, output bit to);
        int budget;
        to  = 1'b0;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; is_64 = w64;
        @(negedge clk);
        start = 1'b0;
        is_signed = 1'($urandom_range(0, 1));
        is_64     = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            in_byte  = stim[i];
            in_valid = 1'b1;
            budget   = 0;
            while (!in_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) to = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            in_byte  = 8'($urandom_range(0, 255));
            if (to) break;
        end
        budget = 0;
        while (!(out_valid || error) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!(out_valid || error)) to = 1'b1;
        lat = budget;
        val = out_value;
        len = out_length;
        vld = out_valid;
        err = error;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic clear_error();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference unsigned LEB128 encoder.
    task automatic enc_u(input logic [63:0] v, output int n);
        logic [6:0] b;
        n = 0;
        do begin
            b = v[6:0];
            v = v >> 7;
            stim[n] = {(v != 64'd0), b};
            n++;
        end while (v != 64'd0);
    endtask

    // Reference signed LEB128 encoder (minimal length).
    task automatic enc_s(input logic signed [63:0] v, output int n);
        logic [6:0] b;
        bit         more;
        n = 0;
        do begin
            b    = v[6:0];
            v    = v >>> 7;
            more = !((v == 64'sd0 && !b[6]) || (v == -64'sd1 && b[6]));
            stim[n] = {more, b};
            n++;
        end while (more);
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; is_64 = 1'b0;
        in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_value, out_length, out_valid, in_ready, error, busy} !== 72'd0) begin
            errors++;
            $display("FAIL reset_outputs: observed value=%h len=%0d vld=%b rdy=%b err=%b busy=%b, required all zero",
                     out_value, out_length, out_valid, in_ready, error, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: observed busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end
    endtask

    // Test-plan vectors; also checks the DONE handshake and result clearing.
    task automatic test_basic();
        case_t       cases[$];
        logic [63:0] val;
        logic [3:0]  len;
        logic        vld, err;
        int          lat;
        bit          to;
        logic [69:0] exp_obs;
        cases.push_back('{1'b0, 1'b1, 3, 80'h268EE5, 64'h0000_0000_0009_8765, 4'd3, 1'b0});
        cases.push_back('{1'b1, 1'b1, 3, 80'h78BBC0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0});
        cases.push_back('{1'b1, 1'b0, 1, 80'h7F,     64'h0000_0000_FFFF_FFFF, 4'd1, 1'b0});
        cases.push_back('{1'b0, 1'b0, 1, 80'h7F,     64'h0000_0000_0000_007F, 4'd1, 1'b0});
        cases.push_back('{1'b1, 1'b1, 1, 80'h40,     64'hFFFF_FFFF_FFFF_FFC0, 4'd1, 1'b0});
        cases.push_back('{1'b1, 1'b0, 1, 80'h40,     64'h0000_0000_FFFF_FFC0, 4'd1, 1'b0});
        cases.push_back('{1'b0, 1'b1, 2, 80'h0080,   64'h0,                   4'd2, 1'b0});
        foreach (cases[k]) begin
            load_bytes(cases[k].bytes);
            exp_q.push_back(cases[k].val);
            exp_len_q.push_back(cases[k].len);
            exp_err_q.push_back(cases[k].err);
            decode(cases[k].sgn, cases[k].w64, cases[k].n, 1'b0, val, len, vld, err, lat, to);
            exp_obs = {2'b10, exp_len_q.pop_front(), exp_q.pop_front()};
            void'(exp_err_q.pop_front());
            checks++;
            if (to) begin
                errors++;
                $display("FAIL basic_timeout[%0d]: observed no result within budget, required result", k);
            end
            checks++;
            if ({vld, err, len, val} !== exp_obs) begin
                errors++;
                $display("FAIL basic_result[%0d]: observed vld=%b err=%b len=%0d val=%h, required vld=1 err=0 len=%0d val=%h",
                         k, vld, err, len, val, exp_obs[67:64], exp_obs[63:0]);
            end
            checks++;
            if (lat !== 0) begin
                errors++;
                $display("FAIL basic_latency[%0d]: observed %0d extra cycles, required 0", k, lat);
            end
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_done_flags[%0d]: observed in_ready=%b busy=%b, required 0 1", k, in_ready, busy);
            end
            release_result();
            checks++;
            if ({out_valid, busy, out_length, out_value} !== 70'd0) begin
                errors++;
                $display("FAIL basic_released[%0d]: observed vld=%b busy=%b len=%0d val=%h, required all zero",
                         k, out_valid, busy, out_length, out_value);
            end
        end
    endtask

    // Legal encodings at the maximum length for each target.
    task automatic test_limits();
        case_t       cases[$];
        logic [63:0] val;
        logic [3:0]  len;
        logic        vld, err;
        int          lat;
        bit          to;
        logic [69:0] exp_obs;
        cases.push_back('{1'b0, 1'b0, 5,  80'h0FFFFFFFFF,           64'h0000_0000_FFFF_FFFF, 4'd5,  1'b0});
        cases.push_back('{1'b1, 1'b0, 5,  80'h7880808080,           64'h0000_0000_8000_0000, 4'd5,  1'b0});
        cases.push_back('{1'b1, 1'b0, 5,  80'h07FFFFFFFF,           64'h0000_0000_7FFF_FFFF, 4'd5,  1'b0});
        cases.push_back('{1'b0, 1'b1, 10, 80'h01FFFFFFFFFFFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0});
        cases.push_back('{1'b1, 1'b1, 10, 80'h7F808080808080808080, 64'h8000_0000_0000_0000, 4'd10, 1'b0});
        cases.push_back('{1'b1, 1'b1, 10, 80'h00FFFFFFFFFFFFFFFFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'd10, 1'b0});
        foreach (cases[k]) begin
            load_bytes(cases[k].bytes);
            exp_q.push_back(cases[k].val);
            exp_len_q.push_back(cases[k].len);
            exp_err_q.push_back(cases[k].err);
            decode(cases[k].sgn, cases[k].w64, cases[k].n, 1'b0, val, len, vld, err, lat, to);
            exp_obs = {2'b10, exp_len_q.pop_front(), exp_q.pop_front()};
            void'(exp_err_q.pop_front());
            checks++;
            if (to || {vld, err, len, val} !== exp_obs) begin
                errors++;
                $display("FAIL limit_result[%0d]: observed to=%b vld=%b err=%b len=%0d val=%h, required vld=1 err=0 len=%0d val=%h",
                         k, to, vld, err, len, val, exp_obs[67:64], exp_obs[63:0]);
            end
            release_result();
        end
    endtask

    // Overlong and out-of-range encodings; ERROR must hold until start.
    task automatic test_malformed();
        case_t       cases[$];
        logic [63:0] val;
        logic [3:0]  len;
        logic        vld, err;
        int          lat;
        bit          to;
        cases.push_back('{1'b0, 1'b0, 5,  80'h8080808080,           64'h0, 4'd0, 1'b1});
        cases.push_back('{1'b0, 1'b0, 5,  80'h1FFFFFFFFF,           64'h0, 4'd0, 1'b1});
        cases.push_back('{1'b1, 1'b0, 5,  80'h7080808080,           64'h0, 4'd0, 1'b1});
        cases.push_back('{1'b1, 1'b0, 5,  80'h08FFFFFFFF,           64'h0, 4'd0, 1'b1});
        cases.push_back('{1'b0, 1'b1, 10, 80'h02FFFFFFFFFFFFFFFFFF, 64'h0, 4'd0, 1'b1});
        cases.push_back('{1'b0, 1'b1, 10, 80'h80808080808080808080, 64'h0, 4'd0, 1'b1});
        cases.push_back('{1'b1, 1'b1, 10, 80'h3F808080808080808080, 64'h0, 4'd0, 1'b1});
        cases.push_back('{1'b1, 1'b1, 10, 80'h40808080808080808080, 64'h0, 4'd0, 1'b1});
        foreach (cases[k]) begin
            load_bytes(cases[k].bytes);
            exp_err_q.push_back(cases[k].err);
            decode(cases[k].sgn, cases[k].w64, cases[k].n, 1'b0, val, len, vld, err, lat, to);
            checks++;
            if (to || {vld, err, lat} !== {1'b0, exp_err_q.pop_front(), 32'd0}) begin
                errors++;
                $display("FAIL malformed_flag[%0d]: observed to=%b vld=%b err=%b lat=%0d, required vld=0 err=1 lat=0",
                         k, to, vld, err, lat);
            end
            repeat (2) @(negedge clk);
            checks++;
            if ({error, out_valid, in_ready, busy} !== 4'b1001) begin
                errors++;
                $display("FAIL malformed_hold[%0d]: observed err=%b vld=%b rdy=%b busy=%b, required 1 0 0 1",
                         k, error, out_valid, in_ready, busy);
            end
            clear_error();
            @(negedge clk);
            checks++;
            if ({error, busy, in_ready} !== 3'b000) begin
                errors++;
                $display("FAIL malformed_exit[%0d]: observed err=%b busy=%b rdy=%b, required 0 0 0",
                         k, error, busy, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] val;
        logic [3:0]  len;
        logic        vld, err;
        int          lat;
        bit          to;
        stim[0] = 8'h01;
        exp_q.push_back(64'd1);
        exp_len_q.push_back(4'd1);
        decode(1'b1, 1'b1, 1, 1'b0, val, len, vld, err, lat, to);
        // Present a byte and a start while DONE; neither may be taken.
        in_byte = 8'h55; in_valid = 1'b1; start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (to || {out_valid, in_ready, error, out_length, out_value} !== {3'b100, exp_len_q[0], exp_q[0]}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: observed vld=%b rdy=%b err=%b len=%0d val=%h, required 1 0 0 len=1 val=1",
                         c, out_valid, in_ready, error, out_length, out_value);
            end
            @(negedge clk);
        end
        void'(exp_q.pop_front());
        void'(exp_len_q.pop_front());
        in_valid = 1'b0; start = 1'b0;
        release_result();
        checks++;
        if ({out_valid, busy, out_value} !== 66'd0) begin
            errors++;
            $display("FAIL backpressure_release: observed vld=%b busy=%b val=%h, required 0 0 0",
                     out_valid, busy, out_value);
        end
        stim[0] = 8'h02;
        decode(1'b0, 1'b1, 1, 1'b0, val, len, vld, err, lat, to);
        checks++;
        if (to || {vld, err, len, val} !== {2'b10, 4'd1, 64'd2}) begin
            errors++;
            $display("FAIL backpressure_next: observed vld=%b err=%b len=%0d val=%h, required vld=1 err=0 len=1 val=2",
                     vld, err, len, val);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        logic [63:0] val;
        logic [3:0]  len;
        logic        vld, err;
        int          lat;
        bit          to;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; is_64 = 1'b1;
        @(negedge clk);
        start = 1'b0; in_byte = 8'h80; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: observed busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_value, out_length, out_valid, in_ready, error, busy} !== 72'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: observed value=%h len=%0d vld=%b rdy=%b err=%b busy=%b, required all zero",
                     out_value, out_length, out_valid, in_ready, error, busy);
        end
        reset = 1'b0;
        stim[0] = 8'h05;
        exp_q.push_back(64'd5);
        exp_len_q.push_back(4'd1);
        decode(1'b0, 1'b1, 1, 1'b0, val, len, vld, err, lat, to);
        checks++;
        if (to || {vld, err, len, val} !== {2'b10, exp_len_q.pop_front(), exp_q.pop_front()}) begin
            errors++;
            $display("FAIL reset_mid_after: observed vld=%b err=%b len=%0d val=%h, required vld=1 err=0 len=1 val=5",
                     vld, err, len, val);
        end
        release_result();
    endtask

    // Random immediates of every kind with idle gaps between bytes.
    task automatic test_back_to_back();
        logic [63:0]        val;
        logic [3:0]         len;
        logic               vld, err;
        int                 lat, n;
        bit                 to;
        logic [63:0]        u;
        logic signed [63:0] s;
        logic signed [31:0] s32;
        logic [69:0]        exp_obs;
        for (int i = 0; i < 32; i++) begin
            case (i % 4)
                0: begin
                    u = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
                    enc_u(u, n);
                    exp_q.push_back(u);
                end
                1: begin
                    s = $signed({32'($urandom), 32'($urandom)}) >>> $urandom_range(0, 63);
                    enc_s(s, n);
                    exp_q.push_back(s);
                end
                2: begin
                    u = {32'd0, 32'($urandom) >> $urandom_range(0, 31)};
                    enc_u(u, n);
                    exp_q.push_back(u);
                end
                default: begin
                    s32 = $signed(32'($urandom)) >>> $urandom_range(0, 31);
                    s   = 64'(s32);
                    enc_s(s, n);
                    exp_q.push_back({32'd0, s32});
                end
            endcase
            exp_len_q.push_back(4'(n));
            decode((i % 2) == 1, (i % 4) < 2, n, 1'b1, val, len, vld, err, lat, to);
            exp_obs = {2'b10, exp_len_q.pop_front(), exp_q.pop_front()};
            checks++;
            if (to || {vld, err, len, val} !== exp_obs) begin
                errors++;
                $display("FAIL random[%0d]: observed to=%b vld=%b err=%b len=%0d val=%h, required vld=1 err=0 len=%0d val=%h",
                         i, to, vld, err, len, val, exp_obs[67:64], exp_obs[63:0]);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limits();
        test_malformed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
